sram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port `sram` block (synchronous write, registered read). Accepts independent read/write requests from ports A and B, grants at most one per cycle (round-robin by default), drives the SRAM control/address/data pins from registers, and returns read data tagged to the originating port with a fixed latency. Sits between the sequencing logic and the shared `sram` instance.

---
 rtl/sram_arbiter_if.sv | 38 +++
 rtl/sram_arbiter.sv | 106 ++++++++++
 tb/tb_sram_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared sram.
// slave  : arbiter side (takes requests, drives grants/read returns/sram pins)
// master : requester + sram side (drives requests and sram read data)
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  a_req;
  logic                  b_req;
  logic                  a_we;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  a_gnt;
  logic                  b_gnt;
  logic                  a_rvalid;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mem_we;
  logic                  mem_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata,
           mem_we, mem_oe, mem_addr, mem_wdata
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata,
           mem_we, mem_oe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous sram.
// Grants at most one request per cycle, registers the sram pins, and returns
// read data two cycles after the grant, tagged with the requesting port.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN: port A always wins conflicts
// (no round-robin pointer); default build is round-robin.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  sram_arbiter_if.slave  bus
);

  logic                  a_gnt;
  logic                  b_gnt;
  logic                  gnt_any;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  mem_we_q,    mem_we_d;
  logic                  mem_oe_q,    mem_oe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  // Read-return pipeline: valid + port id (0 = A, 1 = B)
  logic                  s1_valid_q,  s1_valid_d;
  logic                  s1_port_q,   s1_port_d;
  logic                  s2_valid_q,  s2_valid_d;
  logic                  s2_port_q,   s2_port_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  // Port granted most recently (0 = A, 1 = B); resets to B so A wins first
  logic                  last_q,      last_d;
`endif

  // Grant decision: single requester always wins, conflicts by priority rule
  always_comb begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
    a_gnt = bus.a_req;
    b_gnt = bus.b_req & ~bus.a_req;
`else
    a_gnt = bus.a_req & (~bus.b_req | last_q);
    b_gnt = bus.b_req & (~bus.a_req | ~last_q);
`endif
    gnt_any   = a_gnt | b_gnt;
    sel_we    = b_gnt ? bus.b_we    : bus.a_we;
    sel_addr  = b_gnt ? bus.b_addr  : bus.a_addr;
    sel_wdata = b_gnt ? bus.b_wdata : bus.a_wdata;
  end

  // Next-state for issue stage, read pipeline and arbitration pointer
  always_comb begin
    mem_we_d    = gnt_any & sel_we;
    mem_oe_d    = gnt_any & ~sel_we;
    mem_addr_d  = gnt_any ? sel_addr  : mem_addr_q;
    mem_wdata_d = gnt_any ? sel_wdata : mem_wdata_q;
    s1_valid_d  = gnt_any & ~sel_we;
    s1_port_d   = b_gnt;
    s2_valid_d  = s1_valid_q;
    s2_port_d   = s1_port_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    last_d      = gnt_any ? b_gnt : last_q;
`endif
  end

  // State registers; reset drops any reads still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_port_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_port_q   <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      s1_valid_q  <= s1_valid_d;
      s1_port_q   <= s1_port_d;
      s2_valid_q  <= s2_valid_d;
      s2_port_q   <= s2_port_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.a_gnt     = a_gnt;
  assign bus.b_gnt     = b_gnt;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_oe    = mem_oe_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // sram data_out is already registered, so read data passes straight through
  assign bus.rdata     = bus.mem_rdata;
  assign bus.a_rvalid  = s2_valid_q & ~s2_port_q;
  assign bus.b_rvalid  = s2_valid_q &  s2_port_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural sram and a
// transaction-level reference (memory array + grant order + read queue).
module tb_sram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural single-port sram: synchronous write, registered read
  logic [DW-1:0] sram_mem [16];
  logic [DW-1:0] sram_dout;
  always @(posedge clk) begin
    if (bus.mem_we) sram_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_oe) sram_dout <= sram_mem[bus.mem_addr];
  end
  assign bus.mem_rdata = sram_dout;

  // Reference state
  typedef struct {
    bit            port_b;
    logic [DW-1:0] data;
    int            gcyc;
  } rd_t;
  rd_t           sb[$];
  logic [DW-1:0] mdl_mem [16];
  bit            last_b;
  logic          exp_we, exp_oe;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  bit            a_hold, b_hold;
  bit            started;
  int            cyc;
  int            n_checks;
  int            n_fail;

  // Random driver's current request per port (held while waiting for grant)
  bit            ra_r, ra_w, rb_r, rb_w;
  logic [AW-1:0] ra_a, rb_a;
  logic [DW-1:0] ra_d, rb_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive both ports, check grants and issue stage, update model
  task automatic cycle(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bit ga, gb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    @(posedge clk); #1;
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    @(negedge clk);
    chk("mem_we", bus.mem_we, exp_we);
    chk("mem_oe", bus.mem_oe, exp_oe);
    chk("mem_addr", bus.mem_addr, exp_addr);
    chk("mem_wdata", bus.mem_wdata, exp_wdata);
    if (ar && br) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      ga = 1'b1;
`else
      ga = last_b;
`endif
      gb = !ga;
    end else begin
      ga = ar;
      gb = br;
    end
    chk("a_gnt", bus.a_gnt, ga);
    chk("b_gnt", bus.b_gnt, gb);
    if (ga || gb) begin
      we   = gb ? bw : aw;
      addr = gb ? ba : aa;
      data = gb ? bd : ad;
      if (we) mdl_mem[addr] = data;
      else    sb.push_back('{port_b: gb, data: mdl_mem[addr], gcyc: cyc});
      exp_we = we; exp_oe = !we; exp_addr = addr; exp_wdata = data;
      last_b = gb;
    end else begin
      exp_we = 1'b0; exp_oe = 1'b0;
    end
    a_hold = ar && !ga;
    b_hold = br && !gb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Assert reset asynchronously mid-cycle, hold two cycles, then release
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    sb.delete();
    exp_we = 1'b0; exp_oe = 1'b0; exp_addr = '0; exp_wdata = '0;
    last_b = 1'b1; a_hold = 1'b0; b_hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_oe", bus.mem_oe, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_a_rvalid", bus.a_rvalid, 0);
      chk("rst_b_rvalid", bus.b_rvalid, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every read return is matched against the oldest expected read
  always @(negedge clk) begin
    if (started) begin
      chk("rvalid_excl", bus.a_rvalid & bus.b_rvalid, 0);
      if (sb.size() > 0 && (cyc - sb[0].gcyc) > 2) begin
        n_checks++;
        n_fail++;
        $display("FAIL rvalid_missing: got no rvalid expected port %0d data %0h (cycle %0d)",
                 sb[0].port_b, sb[0].data, cyc);
        void'(sb.pop_front());
      end
      if (bus.a_rvalid || bus.b_rvalid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rvalid_unexpected: got a=%0d b=%0d expected none (cycle %0d)",
                   bus.a_rvalid, bus.b_rvalid, cyc);
        end else begin
          rd_t e;
          e = sb.pop_front();
          chk("rd_latency", cyc - e.gcyc, 2);
          chk("rd_port", bus.b_rvalid, e.port_b);
          chk("rd_data", bus.rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; started = 0;
    exp_we = 0; exp_oe = 0; exp_addr = '0; exp_wdata = '0; last_b = 1;
    a_hold = 0; b_hold = 0;
    rst_n = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset values; grant stays combinational during reset
    chk("init_mem_we", bus.mem_we, 0);
    chk("init_mem_oe", bus.mem_oe, 0);
    chk("init_mem_addr", bus.mem_addr, 0);
    chk("init_mem_wdata", bus.mem_wdata, 0);
    chk("init_a_rvalid", bus.a_rvalid, 0);
    chk("init_b_rvalid", bus.b_rvalid, 0);
    chk("init_a_gnt", bus.a_gnt, 1);
    chk("init_b_gnt", bus.b_gnt, 0);
    bus.a_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    started = 1;

    // Preload every location through port B
    for (int i = 0; i < 16; i++) cycle(0, 0, '0, '0, 1, 1, AW'(i), DW'($urandom));

    // Single write then read on A
    cycle(1, 1, 4'd3, 8'h5A, 0, 0, '0, '0);
    cycle(1, 0, 4'd3, 8'h00, 0, 0, '0, '0);
    idle(3);

    // Conflicting reads after preloading 1 and 2
    cycle(1, 1, 4'd1, 8'h11, 0, 0, '0, '0);
    cycle(0, 0, '0, '0, 1, 1, 4'd2, 8'h22);
    for (int i = 0; i < 6; i++) cycle(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00);

    // Back-to-back read-after-write on B
    cycle(0, 0, '0, '0, 1, 1, 4'd7, 8'hC3);
    cycle(0, 0, '0, '0, 1, 0, 4'd7, 8'h00);

    // Idle window: issue stage must go quiet and hold address
    idle(5);

    // Reset with an A read in flight, then a conflict
    cycle(1, 0, 4'd3, 8'h00, 0, 0, '0, '0);
    do_reset();
    cycle(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00);
    cycle(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00);
    idle(3);

    // Randomized traffic with the hold-until-granted rule
    ra_r = 0; rb_r = 0; ra_w = 0; rb_w = 0; ra_a = '0; rb_a = '0; ra_d = '0; rb_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!a_hold) begin
        ra_r = ($urandom_range(0, 3) != 0);
        ra_w = $urandom_range(0, 1) != 0;
        ra_a = AW'($urandom);
        ra_d = DW'($urandom);
      end
      if (!b_hold) begin
        rb_r = ($urandom_range(0, 3) != 0);
        rb_w = $urandom_range(0, 1) != 0;
        rb_a = AW'($urandom);
        rb_d = DW'($urandom);
      end
      cycle(ra_r, ra_w, ra_a, ra_d, rb_r, rb_w, rb_a, rb_d);
    end
    idle(3);

    // Continuous conflict for 4 cycles, then A drops
    for (int i = 0; i < 4; i++) cycle(1, 0, 4'd5, 8'h00, 1, 0, 4'd6, 8'h00);
    cycle(0, 0, '0, '0, 1, 0, 4'd6, 8'h00);
    idle(4);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
